regfile_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated pending-write scoreboard, for the decode stage of the pipelined core. It provides NRD combinational read ports and two write ports: port 0 for ALU writeback and port 1 for late load returns. Per-register pending bits let decode detect RAW hazards without a separate hazard table. Writes commit on the rising edge, and optional same-cycle bypass gives write-then-read semantics within one cycle.

---
 rtl/regfile_sb.sv | 119 +++++++++++
 tb/tb_regfile_sb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard for RAW hazard detection.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding on rd_data/rd_pend.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NRD        = 2,
    parameter int DBG_REG    = 10,
    parameter int AW         = $clog2(NUM_REGS),
    parameter int CW         = $clog2(NUM_REGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD*AW-1:0]         rd_addr,
    output logic [NRD*DATA_WIDTH-1:0] rd_data,
    output logic [NRD-1:0]            rd_pend,
    input  logic                      we0,
    input  logic [AW-1:0]             wa0,
    input  logic [DATA_WIDTH-1:0]     wd0,
    input  logic                      we1,
    input  logic [AW-1:0]             wa1,
    input  logic [DATA_WIDTH-1:0]     wd1,
    input  logic                      rsv_valid,
    input  logic [AW-1:0]             rsv_addr,
    output logic                      rsv_conflict,
    output logic [CW-1:0]             pend_cnt,
    output logic [DATA_WIDTH-1:0]     dbg_data
);

    localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   pend;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;
    logic [CW-1:0]         clr_num;
    logic [CW-1:0]         cnt_next;
    logic                  wr0;
    logic                  wr1;
    logic                  rsv_hit_nz;

    // Register 0 never commits a write and never holds a reservation.
    assign wr0        = we0 && (wa0 != '0);
    assign wr1        = we1 && (wa1 != '0);
    assign rsv_hit_nz = rsv_valid && (rsv_addr != '0);

    assign rsv_conflict = rsv_hit_nz && pend[rsv_addr];
    assign dbg_data     = mem[DBG_IDX];

    // A reserve to an address masks any clear from a same-cycle write there,
    // so set and clear are disjoint and the count delta is exact.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        clr_num = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rsv_valid && (rsv_addr == AW'(i)) && !pend[i]) begin
                set_vec[i] = 1'b1;
            end
            if (pend[i] && !(rsv_valid && (rsv_addr == AW'(i))) &&
                ((wr0 && (wa0 == AW'(i))) || (wr1 && (wa1 == AW'(i))))) begin
                clr_vec[i] = 1'b1;
            end
            clr_num = clr_num + CW'(clr_vec[i]);
        end
        cnt_next = pend_cnt + CW'(|set_vec) - clr_num;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= (pend | set_vec) & ~clr_vec;
            pend_cnt <= cnt_next;
        end
    end

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  pnd;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = mem[addr];
            pnd  = pend[addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed during reset so reads stay zero.
            if (rst_n) begin
                if (wr0 && (wa0 == addr)) begin
                    data = wd0;
                    pnd  = 1'b0;
                end
                if (wr1 && (wa1 == addr)) begin
                    data = wd1;
                    pnd  = 1'b0;
                end
            end
`endif
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_pend[p]                          = pnd;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb: each vector is one cycle of inputs plus the outputs expected before its edge.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_pend;
    logic          we0 = 1'b0, we1 = 1'b0, rsv_valid = 1'b0;
    logic [AW-1:0] wa0 = '0, wa1 = '0, rsv_addr = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          rsv_conflict;
    logic [CW-1:0] pend_cnt;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int failures = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
        .pend_cnt(pend_cnt), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsa;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic [1:0]    e_pend;
        logic          e_conf;
        logic [CW-1:0] e_cnt;
        logic [DW-1:0] e_dbg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic rv, input logic [AW-1:0] ra, input logic [AW-1:0] p0,
                       input logic [AW-1:0] p1, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                       input logic [1:0] pe, input logic cf, input logic [CW-1:0] cn,
                       input logic [DW-1:0] db);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.rsv = rv; v.rsa = ra; v.ra0 = p0; v.ra1 = p1;
        v.e_rd0 = r0; v.e_rd1 = r1; v.e_pend = pe; v.e_conf = cf; v.e_cnt = cn; v.e_dbg = db;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | rsv rsa | ra0 ra1 | rd0 rd1 pend conf cnt dbg
        add(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 2'b00, 0, 0, 0);
        add(1, 0, 32'h0000FFFF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0, 0, 0);
        add(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5, BYP ? 32'h22 : 32'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 0, 0, 2'b11, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2'b01, 0, 1, 0);
        add(1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 3, BYP ? 32'h33 : 32'h0, BYP ? 32'h33 : 32'h0,
            BYP ? 2'b00 : 2'b11, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h33, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 1, 4, 32'h44, 1, 4, 4, 0, BYP ? 32'h44 : 32'h0, 0, 2'b00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h44, 0, 2'b01, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 8, 8, 9, 0, 0, 2'b00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 9, 8, 9, 0, 0, 2'b01, 0, 2, 0);
        add(1, 8, 32'h88, 1, 9, 32'h99, 1, 6, 8, 9, BYP ? 32'h88 : 32'h0, BYP ? 32'h99 : 32'h0,
            BYP ? 2'b00 : 2'b11, 0, 3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 6, 8, 0, 32'h88, 2'b01, 0, 2, 0);
        add(1, 6, 32'h66, 0, 0, 0, 1, 6, 6, 4, BYP ? 32'h66 : 32'h0, 32'h44,
            BYP ? 2'b10 : 2'b11, 1, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 6, 10, 32'h66, 0, 2'b01, 0, 2, 0);
        add(0, 0, 0, 1, 10, 32'hA0A0, 0, 0, 10, 0, BYP ? 32'hA0A0 : 32'h0, 0, 2'b00, 0, 2, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 32'hA0A0, 0, 2'b00, 0, 2, 32'hA0A0);
        add(0, 0, 0, 1, 0, 32'h5, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2, 32'hA0A0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h44, 2'b10, 0, 2, 32'hA0A0);

        // Reset state, including reads while reset is still asserted.
        repeat (2) @(posedge clk);
        #1;
        check("reset_cnt", 64'(pend_cnt), 64'd0);
        check("reset_dbg", 64'(dbg_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr = {AW'(31 - i), AW'(i)};
            #1;
            check($sformatf("init_rd0_a%0d", i), 64'(rd_data[DW-1:0]), 64'd0);
            check($sformatf("init_rd1_a%0d", 31 - i), 64'(rd_data[2*DW-1:DW]), 64'd0);
            check($sformatf("init_pend_a%0d", i), 64'(rd_pend), 64'd0);
            @(negedge clk);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            we0 = vecs[k].we0; wa0 = vecs[k].wa0; wd0 = vecs[k].wd0;
            we1 = vecs[k].we1; wa1 = vecs[k].wa1; wd1 = vecs[k].wd1;
            rsv_valid = vecs[k].rsv; rsv_addr = vecs[k].rsa;
            rd_addr = {vecs[k].ra1, vecs[k].ra0};
            #1;
            check($sformatf("v%0d_rd0", k), 64'(rd_data[DW-1:0]), 64'(vecs[k].e_rd0));
            check($sformatf("v%0d_rd1", k), 64'(rd_data[2*DW-1:DW]), 64'(vecs[k].e_rd1));
            check($sformatf("v%0d_pend", k), 64'(rd_pend), 64'(vecs[k].e_pend));
            check($sformatf("v%0d_conf", k), 64'(rsv_conflict), 64'(vecs[k].e_conf));
            check($sformatf("v%0d_cnt", k), 64'(pend_cnt), 64'(vecs[k].e_cnt));
            check($sformatf("v%0d_dbg", k), 64'(dbg_data), 64'(vecs[k].e_dbg));
        end

        // Asynchronous reset mid-cycle while a reserve and a write to reg 2 are presented.
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd2;
        rd_addr = {5'd6, 5'd2};
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd0", 64'(rd_data[DW-1:0]), 64'd0);
        check("arst_rd1", 64'(rd_data[2*DW-1:DW]), 64'd0);
        check("arst_pend", 64'(rd_pend), 64'd0);
        check("arst_cnt", 64'(pend_cnt), 64'd0);
        check("arst_dbg", 64'(dbg_data), 64'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("post_rst_rd2", 64'(rd_data[DW-1:0]), 64'd0);
        check("post_rst_pend2", 64'(rd_pend), 64'd0);
        @(negedge clk);
        #1;
        check("post_rst_rd2_later", 64'(rd_data[DW-1:0]), 64'd0);
        check("post_rst_pend_later", 64'(rd_pend), 64'd0);
        check("post_rst_cnt", 64'(pend_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
